// File: rtl/scl_pix_pack_pkg.sv
// Shared scaler definitions: pixel/word widths, line-counter width, default line gap,
// and the word record carried through the output FIFO.
package scl_pix_pack_pkg;

    localparam int PIX_W       = 8;
    localparam int WORD_W      = 32;
    localparam int BE_W        = WORD_W / PIX_W;
    localparam int LINE_CNT_W  = 10;
    localparam int GAP_LEN_DEF = 4;

    typedef struct packed {
        logic              last;
        logic [BE_W-1:0]   be;
        logic [WORD_W-1:0] data;
    } word_t;

    // Byte-enable mask for a partial word holding n pixels in the low slots.
    function automatic logic [BE_W-1:0] be_mask(input logic [1:0] n);
        logic [BE_W-1:0] m;
        for (int i = 0; i < BE_W; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/scl_pix_pack_if.sv
// Pixel input and packed-word output stream of the packer.
interface scl_pix_pack_if;
    import scl_pix_pack_pkg::*;

    logic              scl_o_data_en;
    logic [PIX_W-1:0]  scl_pix;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [BE_W-1:0]   out_be;
    logic              out_last;

    modport master (
        input  scl_o_data_en, scl_pix, out_ready,
        output out_valid, out_data, out_be, out_last
    );

    modport slave (
        output scl_o_data_en, scl_pix, out_ready,
        input  out_valid, out_data, out_be, out_last
    );

endinterface

// File: rtl/scl_word_fifo.sv
// Fall-through word FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module scl_word_fifo
    import scl_pix_pack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  word_t push_word,
    input  logic  pop,
    output word_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    word_t       mem_reg [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_word;
    end

    // Storage is not reset, so the head is forced to zero while nothing is queued.
    assign head = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/scl_pix_pack.sv
// Packs decimated 8-bit pixels into 32-bit words, detects line ends from enable gaps,
// and queues words with byte enables and a last flag.
module scl_pix_pack
    import scl_pix_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_LEN    = GAP_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    scl_pix_pack_if.master        bus,
    output logic [LINE_CNT_W-1:0] line_words,
    output logic                  ovf_err,
    input  logic                  err_clr
);

    localparam int IDLE_W = $clog2(GAP_LEN + 1);

    logic [1:0]            idx_reg, idx_next;
    logic [WORD_W-1:0]     asm_reg, asm_next;
    logic [WORD_W-1:0]     pend_reg, pend_next;
    logic                  pend_valid_reg, pend_valid_next;
    logic [IDLE_W-1:0]     idle_reg, idle_next;
    logic                  seen_reg, seen_next;
    logic [LINE_CNT_W-1:0] cnt_reg, cnt_inc;
    logic [LINE_CNT_W-1:0] line_words_reg;
    logic                  ovf_reg;

    logic  en;
    logic  line_end;
    logic  push;
    word_t push_word;
    word_t head;
    logic  full;
    logic  empty;
    logic  drop;

    assign en       = bus.scl_o_data_en;
    assign line_end = !en && seen_reg && (idle_reg == IDLE_W'(GAP_LEN - 1));

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (en && pend_valid_reg) begin
            push           = 1'b1;
            push_word.data = pend_reg;
            push_word.be   = '1;
        end else if (line_end) begin
            push           = 1'b1;
            push_word.last = 1'b1;
            if (idx_reg == 2'd0) begin
                push_word.data = pend_reg;
                push_word.be   = '1;
            end else begin
                push_word.data = asm_reg;
                push_word.be   = be_mask(idx_reg);
            end
        end
    end

    always_comb begin
        idx_next        = idx_reg;
        asm_next        = asm_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        idle_next       = idle_reg;
        seen_next       = seen_reg;
        if (en) begin
            // Slot 0 starts a fresh word so a later partial flush carries zero padding.
            if (idx_reg == 2'd0) asm_next = '0;
            asm_next[idx_reg*PIX_W +: PIX_W] = bus.scl_pix;
            idx_next  = idx_reg + 2'd1;
            idle_next = '0;
            seen_next = 1'b1;
            if (pend_valid_reg) pend_valid_next = 1'b0;
            if (idx_reg == 2'd3) begin
                pend_next       = asm_next;
                pend_valid_next = 1'b1;
            end
        end else begin
            if (idle_reg != IDLE_W'(GAP_LEN)) idle_next = idle_reg + 1'b1;
            if (line_end) begin
                idx_next        = 2'd0;
                asm_next        = '0;
                pend_valid_next = 1'b0;
                seen_next       = 1'b0;
            end
        end
    end

    assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
    // full implies a head word exists, so out_ready alone decides whether a slot frees up.
    assign drop    = push && full && !bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg        <= '0;
            asm_reg        <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            idle_reg       <= '0;
            seen_reg       <= 1'b0;
            cnt_reg        <= '0;
            line_words_reg <= '0;
            ovf_reg        <= 1'b0;
        end else begin
            idx_reg        <= idx_next;
            asm_reg        <= asm_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            idle_reg       <= idle_next;
            seen_reg       <= seen_next;
            if (push) begin
                if (push_word.last) begin
                    line_words_reg <= cnt_inc;
                    cnt_reg        <= '0;
                end else begin
                    cnt_reg <= cnt_inc;
                end
            end
            if (drop)         ovf_reg <= 1'b1;
            else if (err_clr) ovf_reg <= 1'b0;
        end
    end

    scl_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_word (push_word),
        .pop       (bus.out_ready),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = head.data;
    assign bus.out_be    = head.be;
    assign bus.out_last  = head.last;
    assign line_words    = line_words_reg;
    assign ovf_err       = ovf_reg;

endmodule
